bus_arbiter_n: RTL and testbench

BUS_ARBITER_N -- requirements
Module: bus_arbiter_n

---
 rtl/bus_arbiter_n.sv | 247 ++++++++++++++++++++++++
 tb/tb_bus_arbiter_n.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_n.sv
// Multi-core memory bus arbiter with snoop broadcast, cache-to-cache
// forwarding, block write-back and single-word instruction fetch.
module bus_arbiter_n #(
  parameter int unsigned CPUS        = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned BLOCK_WORDS = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS*ADDR_W-1:0]   iaddr,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS*WORD_W-1:0]   iload,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS*ADDR_W-1:0]   daddr,
  input  logic [CPUS*WORD_W-1:0]   dstore,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*WORD_W-1:0]   dload,
  input  logic [CPUS-1:0]          cctrans,
  input  logic [CPUS-1:0]          ccwrite,
  output logic [CPUS-1:0]          ccwait,
  output logic [CPUS-1:0]          ccinv,
  output logic [CPUS*ADDR_W-1:0]   ccsnoopaddr,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [ADDR_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  logic [1:0]               ramstate
);

  localparam int unsigned IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int unsigned CNT_W = $clog2(BLOCK_WORDS + 1);
  localparam logic [1:0]  RAM_ACCESS = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SNOOP  = 3'd1,
    RAMRD  = 3'd2,
    C2C    = 3'd3,
    WB     = 3'd4,
    IFETCH = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] supplier_q, supplier_d;
  logic [IDX_W-1:0] dptr_q, dptr_d;
  logic [IDX_W-1:0] iptr_q, iptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Per-core views of the flattened buses
  logic [ADDR_W-1:0] iaddr_a       [CPUS];
  logic [ADDR_W-1:0] daddr_a       [CPUS];
  logic [WORD_W-1:0] dstore_a      [CPUS];
  logic [WORD_W-1:0] dload_a       [CPUS];
  logic [WORD_W-1:0] iload_a       [CPUS];
  logic [ADDR_W-1:0] ccsnoopaddr_a [CPUS];

  logic             d_any, i_any, s_hit;
  logic [IDX_W-1:0] d_pick, i_pick, s_pick;
  logic             access;
  logic             last_word;
  logic             grant_req;
  logic             word_ok;

  for (genvar k = 0; k < CPUS; k++) begin : g_core
    assign iaddr_a[k]  = iaddr[k*ADDR_W +: ADDR_W];
    assign daddr_a[k]  = daddr[k*ADDR_W +: ADDR_W];
    assign dstore_a[k] = dstore[k*WORD_W +: WORD_W];
    assign dload[k*WORD_W +: WORD_W]        = dload_a[k];
    assign iload[k*WORD_W +: WORD_W]        = iload_a[k];
    assign ccsnoopaddr[k*ADDR_W +: ADDR_W]  = ccsnoopaddr_a[k];
  end

  // Core index offset positions after base, wrapping modulo CPUS
  function automatic logic [IDX_W-1:0] ring(input logic [IDX_W-1:0] base,
                                            input int unsigned       off);
    return IDX_W'((32'(base) + off) % CPUS);
  endfunction

  // Round-robin successor used for both pointers
  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] x);
    if (32'(x) >= CPUS - 1) return '0;
    return x + IDX_W'(1);
  endfunction

  assign access    = (ramstate == RAM_ACCESS);
  assign last_word = (cnt_q == CNT_W'(BLOCK_WORDS - 1));
  assign word_ok   = grant_req && access;

  // Whether the granted core still holds the request being serviced
  always_comb begin
    grant_req = 1'b0;
    case (state_q)
      RAMRD, C2C: grant_req = dREN[grant_q];
      WB:         grant_req = dWEN[grant_q];
      IFETCH:     grant_req = iREN[grant_q];
      default:    grant_req = 1'b0;
    endcase
  end

  // Round-robin pickers for data, instruction and snoop-supplier search
  always_comb begin
    d_any  = 1'b0;
    d_pick = dptr_q;
    i_any  = 1'b0;
    i_pick = iptr_q;
    s_hit  = 1'b0;
    s_pick = grant_q;
    for (int unsigned i = 0; i < CPUS; i++) begin
      if (!d_any && (dREN[ring(dptr_q, i)] || dWEN[ring(dptr_q, i)])) begin
        d_any  = 1'b1;
        d_pick = ring(dptr_q, i);
      end
      if (!i_any && iREN[ring(iptr_q, i)]) begin
        i_any  = 1'b1;
        i_pick = ring(iptr_q, i);
      end
    end
    for (int unsigned i = 1; i < CPUS; i++) begin
      if (!s_hit && cctrans[ring(grant_q, i)] && ccwrite[ring(grant_q, i)]) begin
        s_hit  = 1'b1;
        s_pick = ring(grant_q, i);
      end
    end
  end

  // Next-state and bus-output decode
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    supplier_d = supplier_q;
    cnt_d      = cnt_q;
    dptr_d     = dptr_q;
    iptr_d     = iptr_q;
    iwait      = '1;
    dwait      = '1;
    ccwait     = '0;
    ccinv      = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    for (int unsigned k = 0; k < CPUS; k++) begin
      dload_a[k]       = ramload;
      iload_a[k]       = ramload;
      ccsnoopaddr_a[k] = '0;
    end

    // Other cores are held off and snooped for the whole read transaction
    if (state_q inside {SNOOP, RAMRD, C2C}) begin
      for (int unsigned k = 0; k < CPUS; k++) begin
        if (IDX_W'(k) != grant_q) begin
          ccwait[k]        = 1'b1;
          ccsnoopaddr_a[k] = daddr_a[grant_q];
          ccinv[k]         = cctrans[grant_q] && ccwrite[grant_q];
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (d_any) begin
          grant_d = d_pick;
          cnt_d   = '0;
          state_d = dWEN[d_pick] ? WB : SNOOP;
        end else if (i_any) begin
          grant_d = i_pick;
          state_d = IFETCH;
        end
      end
      SNOOP: begin
        if (s_hit) begin
          supplier_d = s_pick;
          state_d    = C2C;
        end else begin
          state_d = RAMRD;
        end
      end
      RAMRD: begin
        ramREN  = 1'b1;
        ramaddr = daddr_a[grant_q];
        if (word_ok) dwait[grant_q] = 1'b0;
      end
      C2C: begin
        dload_a[grant_q] = dstore_a[supplier_q];
        ramWEN           = 1'b1;
        ramaddr          = daddr_a[grant_q];
        ramstore         = dstore_a[supplier_q];
        if (word_ok) begin
          dwait[grant_q]    = 1'b0;
          dwait[supplier_q] = 1'b0;
        end
      end
      WB: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr_a[grant_q];
        ramstore = dstore_a[grant_q];
        if (word_ok) dwait[grant_q] = 1'b0;
      end
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr_a[grant_q];
        if (word_ok) iwait[grant_q] = 1'b0;
        if (!grant_req || access) begin
          state_d = IDLE;
          iptr_d  = inc_wrap(grant_q);
        end
      end
      default: state_d = IDLE;
    endcase

    // Block transfer progress: abort on dropped request, finish on last word
    if (state_q inside {RAMRD, C2C, WB}) begin
      if (!grant_req || (access && last_word)) begin
        state_d = IDLE;
        cnt_d   = '0;
        dptr_d  = inc_wrap(grant_q);
      end else if (access) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State and arbitration registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      supplier_q <= '0;
      cnt_q      <= '0;
      dptr_q     <= '0;
      iptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      supplier_q <= supplier_d;
      cnt_q      <= cnt_d;
      dptr_q     <= dptr_d;
      iptr_q     <= iptr_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Directed bench for bus_arbiter_n with four cores and two-word blocks.
module tb_bus_arbiter_n;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned WW = 32;
  localparam int unsigned BW = 2;

  localparam logic [1:0] FREE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic              CLK;
  logic              RST;
  logic [N-1:0]      iREN, iwait, dREN, dWEN, dwait;
  logic [N-1:0]      cctrans, ccwrite, ccwait, ccinv;
  logic [N*AW-1:0]   iaddr, daddr, ccsnoopaddr;
  logic [N*WW-1:0]   iload, dstore, dload;
  logic              ramREN, ramWEN;
  logic [AW-1:0]     ramaddr;
  logic [WW-1:0]     ramstore, ramload;
  logic [1:0]        ramstate;

  int n_assert = 0;
  int n_fail   = 0;
  logic [N-1:0] gm;

  bus_arbiter_n #(.CPUS(N), .ADDR_W(AW), .WORD_W(WW), .BLOCK_WORDS(BW)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] w32(input logic [N*32-1:0] v, input int k);
    return v[k*32 +: 32];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST = 1'b1;
    clear_inputs();
    #1;
    chk("reset_pulse_dwait", 64'(dwait), 64'(4'hF));
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    ramload = 32'h1234_5678;

    // Reset values
    @(negedge CLK); #1;
    chk("rst_dwait", 64'(dwait), 64'(4'hF));
    chk("rst_iwait", 64'(iwait), 64'(4'hF));
    chk("rst_ccwait", 64'(ccwait), 64'(0));
    chk("rst_ramren", 64'(ramREN), 64'(0));
    chk("rst_dload2", 64'(w32(dload, 2)), 64'(32'h1234_5678));
    chk("rst_iload1", 64'(w32(iload, 1)), 64'(32'h1234_5678));
    // Requests held while reset is high are not granted
    dREN = 4'b0001; ramstate = ACC;
    @(negedge CLK); #1;
    chk("rst_hold_ccwait", 64'(ccwait), 64'(0));
    chk("rst_hold_ramren", 64'(ramREN), 64'(0));

    // Plain block read by core 0 from RAM
    @(negedge CLK);
    RST = 1'b0; dREN = 4'b0001; daddr[0*AW +: AW] = 32'h100; ramstate = FREE; #1;
    chk("rd_idle_ramren", 64'(ramREN), 64'(0));
    @(negedge CLK); #1;
    chk("rd_snoop_ccwait", 64'(ccwait), 64'(4'b1110));
    chk("rd_snoop_addr1", 64'(w32(ccsnoopaddr, 1)), 64'(32'h100));
    chk("rd_snoop_addr0", 64'(w32(ccsnoopaddr, 0)), 64'(0));
    chk("rd_snoop_ramren", 64'(ramREN), 64'(0));
    chk("rd_snoop_dwait", 64'(dwait), 64'(4'hF));
    @(negedge CLK); ramstate = BUSY; #1;
    chk("rd_busy_ramren", 64'(ramREN), 64'(1));
    chk("rd_busy_ramwen", 64'(ramWEN), 64'(0));
    chk("rd_busy_ramaddr", 64'(ramaddr), 64'(32'h100));
    chk("rd_busy_dwait", 64'(dwait), 64'(4'hF));
    chk("rd_busy_ccwait", 64'(ccwait), 64'(4'b1110));
    @(negedge CLK); ramstate = ACC; ramload = 32'hAAAA_0001; #1;
    chk("rd_w1_dwait", 64'(dwait), 64'(4'b1110));
    chk("rd_w1_dload0", 64'(w32(dload, 0)), 64'(32'hAAAA_0001));
    @(negedge CLK); daddr[0*AW +: AW] = 32'h104; ramstate = ERR; #1;
    chk("rd_err_dwait", 64'(dwait), 64'(4'hF));
    chk("rd_err_ramaddr", 64'(ramaddr), 64'(32'h104));
    @(negedge CLK); ramstate = ACC; ramload = 32'hAAAA_0002; #1;
    chk("rd_w2_dwait", 64'(dwait), 64'(4'b1110));
    chk("rd_w2_ccwait", 64'(ccwait), 64'(4'b1110));

    // Back in IDLE; data pointer now favours core 1
    @(negedge CLK);
    dREN = 4'b0011; daddr[1*AW +: AW] = 32'h200; ramstate = FREE; #1;
    chk("rr_idle_ccwait", 64'(ccwait), 64'(0));
    chk("rr_idle_ramren", 64'(ramREN), 64'(0));
    chk("rr_idle_dwait", 64'(dwait), 64'(4'hF));
    @(negedge CLK); #1;
    chk("rr_snoop_ccwait", 64'(ccwait), 64'(4'b1101));
    chk("rr_snoop_addr0", 64'(w32(ccsnoopaddr, 0)), 64'(32'h200));
    @(negedge CLK); ramstate = ACC; ramload = 32'hBBBB_0001; #1;
    chk("c1_w1_dwait", 64'(dwait), 64'(4'b1101));
    chk("c1_w1_ramaddr", 64'(ramaddr), 64'(32'h200));
    chk("c1_w1_dload1", 64'(w32(dload, 1)), 64'(32'hBBBB_0001));
    // Core 1 drops its read after the first word
    @(negedge CLK); dREN = 4'b0001; #1;
    chk("drop_no_pulse", 64'(dwait), 64'(4'hF));

    // Cache-to-cache transfer: core 1 holds the block modified
    @(negedge CLK);
    cctrans = 4'b0010; ccwrite = 4'b0010; dstore[1*WW +: WW] = 32'hDEAD_BEEF;
    daddr[0*AW +: AW] = 32'h100; ramstate = FREE; #1;
    chk("c2c_idle_ramwen", 64'(ramWEN), 64'(0));
    chk("c2c_idle_ccwait", 64'(ccwait), 64'(0));
    @(negedge CLK); #1;
    chk("c2c_snoop_ccwait", 64'(ccwait), 64'(4'b1110));
    chk("c2c_snoop_ccinv", 64'(ccinv), 64'(0));
    @(negedge CLK); ramstate = BUSY; #1;
    chk("c2c_busy_ramwen", 64'(ramWEN), 64'(1));
    chk("c2c_busy_ramren", 64'(ramREN), 64'(0));
    chk("c2c_busy_ramstore", 64'(ramstore), 64'(32'hDEAD_BEEF));
    chk("c2c_busy_ramaddr", 64'(ramaddr), 64'(32'h100));
    chk("c2c_busy_dload0", 64'(w32(dload, 0)), 64'(32'hDEAD_BEEF));
    chk("c2c_busy_dwait", 64'(dwait), 64'(4'hF));
    @(negedge CLK); ramstate = ACC; #1;
    chk("c2c_w1_dwait", 64'(dwait), 64'(4'b1100));
    @(negedge CLK); daddr[0*AW +: AW] = 32'h104; ramstate = BUSY; #1;
    chk("c2c_w2_ramwen", 64'(ramWEN), 64'(1));
    chk("c2c_w2_ramaddr", 64'(ramaddr), 64'(32'h104));
    chk("c2c_w2_dwait", 64'(dwait), 64'(4'hF));
    // Reset lands during the second word
    @(negedge CLK); ramstate = ACC; ramload = 32'h0BAD_0000; RST = 1'b1; #1;
    chk("mid_rst_dwait", 64'(dwait), 64'(4'hF));
    chk("mid_rst_ramwen", 64'(ramWEN), 64'(0));
    chk("mid_rst_ramaddr", 64'(ramaddr), 64'(0));
    chk("mid_rst_ccwait", 64'(ccwait), 64'(0));
    chk("mid_rst_dload0", 64'(w32(dload, 0)), 64'(32'h0BAD_0000));
    @(negedge CLK);
    RST = 1'b0; dREN = 4'b1001; cctrans = '0; ccwrite = '0;
    daddr[3*AW +: AW] = 32'h300; ramstate = FREE; #1;
    chk("post_rst_ccwait", 64'(ccwait), 64'(0));
    @(negedge CLK); #1;
    chk("post_rst_grant0", 64'(ccwait), 64'(4'b1110));
    chk("post_rst_addr3", 64'(w32(ccsnoopaddr, 3)), 64'(32'h104));
    @(negedge CLK); dREN = 4'b0000; ramstate = ACC; #1;
    chk("post_rst_drop", 64'(dwait), 64'(4'hF));

    // Four cores contending: data round robin starves instruction fetch
    pulse_reset();
    for (int k = 0; k < 4; k++) daddr[k*AW +: AW] = 32'h1000 + 32'(k) * 32'h10;
    dREN = 4'b1111; iREN = 4'b0100; iaddr[2*AW +: AW] = 32'h4000; ramstate = ACC; #1;
    for (int n = 0; n < 5; n++) begin
      gm = 4'(~(4'b0001 << (n % 4)));
      chk("rr4_idle_iwait", 64'(iwait), 64'(4'hF));
      chk("rr4_idle_ramren", 64'(ramREN), 64'(0));
      @(negedge CLK); #1;
      chk("rr4_snoop_ccwait", 64'(ccwait), 64'(gm));
      @(negedge CLK); #1;
      chk("rr4_w1_dwait", 64'(dwait), 64'(gm));
      @(negedge CLK); #1;
      chk("rr4_w2_dwait", 64'(dwait), 64'(gm));
      chk("rr4_w2_iwait", 64'(iwait), 64'(4'hF));
      @(negedge CLK);
      if (n == 4) dREN = 4'b0000;
      #1;
    end
    chk("if_idle_ramren", 64'(ramREN), 64'(0));
    @(negedge CLK); ramload = 32'h1F1F_1F1F; #1;
    chk("if2_iwait", 64'(iwait), 64'(4'b1011));
    chk("if2_ramren", 64'(ramREN), 64'(1));
    chk("if2_ramwen", 64'(ramWEN), 64'(0));
    chk("if2_ramaddr", 64'(ramaddr), 64'(32'h4000));
    chk("if2_iload2", 64'(w32(iload, 2)), 64'(32'h1F1F_1F1F));
    @(negedge CLK); iREN = '0; #1;
    chk("if2_done_iwait", 64'(iwait), 64'(4'hF));
    chk("if2_done_ramren", 64'(ramREN), 64'(0));

    // Write-back beats a same-cycle instruction fetch
    pulse_reset();
    dWEN = 4'b0010; daddr[1*AW +: AW] = 32'h500; dstore[1*WW +: WW] = 32'h5555_AAAA;
    iREN = 4'b0001; iaddr[0*AW +: AW] = 32'h600; ramstate = FREE; #1;
    chk("wb_idle_iwait", 64'(iwait), 64'(4'hF));
    @(negedge CLK); ramstate = BUSY; #1;
    chk("wb_busy_ramwen", 64'(ramWEN), 64'(1));
    chk("wb_busy_ramren", 64'(ramREN), 64'(0));
    chk("wb_busy_ramstore", 64'(ramstore), 64'(32'h5555_AAAA));
    chk("wb_busy_ramaddr", 64'(ramaddr), 64'(32'h500));
    chk("wb_busy_ccwait", 64'(ccwait), 64'(0));
    chk("wb_busy_dwait", 64'(dwait), 64'(4'hF));
    @(negedge CLK); ramstate = ACC; #1;
    chk("wb_w1_dwait", 64'(dwait), 64'(4'b1101));
    chk("wb_w1_iwait", 64'(iwait), 64'(4'hF));
    @(negedge CLK); daddr[1*AW +: AW] = 32'h504; dstore[1*WW +: WW] = 32'h5555_AAAB; #1;
    chk("wb_w2_dwait", 64'(dwait), 64'(4'b1101));
    chk("wb_w2_ramaddr", 64'(ramaddr), 64'(32'h504));
    chk("wb_w2_ramstore", 64'(ramstore), 64'(32'h5555_AAAB));
    @(negedge CLK); dWEN = '0; ramstate = BUSY; #1;
    chk("wb_idle2_ramwen", 64'(ramWEN), 64'(0));
    chk("wb_idle2_ramren", 64'(ramREN), 64'(0));
    @(negedge CLK); #1;
    chk("if0_busy_ramren", 64'(ramREN), 64'(1));
    chk("if0_busy_ramaddr", 64'(ramaddr), 64'(32'h600));
    chk("if0_busy_iwait", 64'(iwait), 64'(4'hF));
    @(negedge CLK); ramstate = ACC; ramload = 32'h77; #1;
    chk("if0_acc_iwait", 64'(iwait), 64'(4'b1110));
    chk("if0_acc_iload0", 64'(w32(iload, 0)), 64'(32'h77));
    @(negedge CLK); iREN = '0; #1;
    chk("if0_done_iwait", 64'(iwait), 64'(4'hF));
    chk("if0_done_ramren", 64'(ramREN), 64'(0));

    // Requester with write intent invalidates the other copies
    pulse_reset();
    dREN = 4'b0100; daddr[2*AW +: AW] = 32'h700;
    cctrans = 4'b0100; ccwrite = 4'b0100; ramstate = FREE; #1;
    @(negedge CLK); #1;
    chk("inv_snoop_ccinv", 64'(ccinv), 64'(4'b1011));
    chk("inv_snoop_ccwait", 64'(ccwait), 64'(4'b1011));
    chk("inv_snoop_addr3", 64'(w32(ccsnoopaddr, 3)), 64'(32'h700));
    @(negedge CLK); ramstate = BUSY; #1;
    chk("inv_rd_ramren", 64'(ramREN), 64'(1));
    chk("inv_rd_ramwen", 64'(ramWEN), 64'(0));
    chk("inv_rd_ccinv", 64'(ccinv), 64'(4'b1011));
    @(negedge CLK); dREN = '0; ramstate = ACC; #1;
    chk("inv_drop_dwait", 64'(dwait), 64'(4'hF));
    @(negedge CLK); #1;
    chk("inv_idle_ccinv", 64'(ccinv), 64'(0));
    chk("inv_idle_ccwait", 64'(ccwait), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
